uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
Transmit-side controller that sequences a UART frame using the oversampled tick from the baud rate generator. It accepts a byte over a valid/ready handshake, aligns the frame start to a tick, and holds each bit for exactly OVERSAMPLE ticks. The frame is start, data LSB-first, optional parity, then stop. It sits between the host-side byte source and the tx pin, with the baud rate generator instantiated alongside it.

Parameters:
DATABITS, 8, number of data bits per frame (5..9)
OVERSAMPLE, 16, ticks per bit; must match the generator's oversample setting (>=2)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOPBITS, 1, number of stop bits (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-clk pulse from the baud rate generator, OVERSAMPLE per bit period
data  in  DATABITS  byte to send; sampled only on acceptance
valid  in  1  data is valid
ready  out  1  sequencer can accept; registered
tx  out  1  serial line, idle high; registered
busy  out  1  high from acceptance through the end of the last stop bit

Behaviour:
- Reset (rst low, asynchronous) forces: tx=1, ready=1, busy=0, state IDLE, all counters 0, shift register 0. Reset mid-frame aborts the frame immediately; there is no partial-bit completion.
- Acceptance: a byte is accepted on the clk edge where valid && ready. On that edge:
  - data is latched;
  - ready goes 0 and busy goes 1;
  - state goes to ALIGN.
  A tick present in the acceptance cycle is not counted.
- valid is ignored while ready=0. data is not re-sampled after acceptance.
- States: IDLE -> ALIGN -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
- ALIGN: tx stays 1. On the first tick, tx<=0, the tick counter is cleared, and state goes to START. Consequence: every bit, including the start bit, spans exactly OVERSAMPLE ticks.
- Tick counter: width clog2(OVERSAMPLE). It increments only on tick. The bit ends on the tick where the counter equals OVERSAMPLE-1; on that same edge the counter wraps to 0 and tx takes the next bit value.
- START end: tx<=data[0], bit index cleared, state DATA.
- DATA: bit index has width clog2(DATABITS). On each bit end:
  - if the index is not DATABITS-1: shift, output the next bit, index+1;
  - at index DATABITS-1: tx<=parity bit and state PARITY (if enabled), otherwise tx<=1 and state STOP.
- Parity is computed on the latched data: even -> XOR of the bits; odd -> inverted XOR.
- PARITY end: tx<=1, state STOP.
- STOP: lasts STOPBITS*OVERSAMPLE ticks. A stop counter is used when STOPBITS=2. On the final stop tick:
  - state IDLE, ready<=1, busy<=0 on the same edge;
  - tx remains 1.
- Back-to-back: if valid is held high, the next byte is accepted on the first edge where ready=1. That is one clk after the stop end, followed by a fresh ALIGN. There is no gap beyond alignment to the next tick.
- tick asserted in consecutive cycles is legal: each cycle counts as one tick.
- Without tick, the sequencer stalls indefinitely in its current state with outputs held.
- Frame length from the first tick in ALIGN to ready: (1 + DATABITS + (PARITY!=0) + STOPBITS) * OVERSAMPLE ticks.

Test Plan:
- Bench setup: clk period 10 ns; tick pulsed 1 cycle in 4 (64 clk per bit); defaults unless stated.
- Reset then idle: release rst and hold valid=0 for 1000 clk -> tx=1, ready=1, busy=0 throughout; asserting rst low mid-cycle forces outputs immediately (asynchronously).
- Send 0x55, no parity: accept, then tx falls on the first tick after acceptance -> tx pattern 0,1,0,1,0,1,0,1,0,1. Each level lasts 64 clk. ready returns to 1 exactly 640 clk after the tx falling edge.
- PARITY=2, data 0x07 -> parity bit 1. PARITY=1, data 0x07 -> parity bit 0. Frame is 11 bits; with STOPBITS=2 the stop level lasts 128 clk.
- Back-to-back 0xA3 then 0x3C with valid held: second accepted 1 clk after ready rises. The second start edge occurs at the next tick. Decoded bytes match.
- valid toggled with data changing while busy -> no extra acceptance; the transmitted byte equals the originally latched value.
- rst asserted during DATA bit 4 -> tx=1, ready=1 immediately. The next frame after release is complete and correct.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit frame sequencer driven by an oversampled baud tick
//
// Accepts a data word over valid/ready, waits for the next tick to start the frame,
// then shifts out start, data LSB-first, optional parity and stop bits, each bit held
// for OVERSAMPLE ticks.
//
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   tick_i   one-cycle oversample tick from the baud rate generator
//   data_i   word to send, sampled only on acceptance
//   valid_i  data_i is valid
//   ready_o  sequencer can accept a word (registered)
//   tx_o     serial line, idle high (registered)
//   busy_o   high from acceptance through the end of the last stop bit
module uart_tx_sequencer #(
    parameter int DATABITS   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOPBITS   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic [DATABITS-1:0] data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                tx_o,
    output logic                busy_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATABITS);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATABITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATABITS-1:0]   shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  bit_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_cnt_d = stop_cnt_q;
        bit_end    = tick_i && (tick_cnt_q == TICK_LAST);

        // The tick counter only runs once the start bit is on the line; the
        // explicit wrap keeps non-power-of-two OVERSAMPLE values correct.
        if (tick_i && (state_q != S_IDLE) && (state_q != S_ALIGN)) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (valid_i && ready_q) begin
                    shift_d    = data_i;
                    // Parity is fixed at acceptance since the shift register is consumed.
                    par_d      = (PARITY == 1) ? ~^data_i : ^data_i;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (tick_i) begin
                    tx_d       = 1'b0;
                    tick_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q != BIT_LAST) begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else if (PARITY != 0) begin
                        tx_d    = par_q;
                        state_d = S_PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if ((STOPBITS == 2) && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ready_o = ready_q;
    assign tx_o    = tx_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - self-checking bench for uart_tx_sequencer
module tb_uart_tx_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [2:0] valid;
    logic [7:0] data [3];
    logic [2:0] tx;
    logic [2:0] ready;
    logic [2:0] busy;
    int         tph;
    int         errors;
    int         checks;

    // Unit 0: no parity, 1 stop. Unit 1: even parity, 2 stops. Unit 2: odd parity, 1 stop.
    uart_tx_sequencer #(.DATABITS(8), .OVERSAMPLE(16), .PARITY(0), .STOPBITS(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .data_i(data[0]), .valid_i(valid[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]));
    uart_tx_sequencer #(.DATABITS(8), .OVERSAMPLE(16), .PARITY(2), .STOPBITS(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .data_i(data[1]), .valid_i(valid[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]));
    uart_tx_sequencer #(.DATABITS(8), .OVERSAMPLE(16), .PARITY(1), .STOPBITS(1)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .data_i(data[2]), .valid_i(valid[2]),
        .ready_o(ready[2]), .tx_o(tx[2]), .busy_o(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One tick every 4 clocks, changed on the falling edge.
    initial begin
        tph  = 0;
        tick = 1'b0;
    end
    always @(negedge clk) begin
        tph  = (tph + 1) % 4;
        tick = (tph == 0);
    end

    // Expected line level for frame bit k: start, data LSB-first, parity, then stop.
    function automatic logic exp_bit(input logic [7:0] d, input int par, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && par != 0) return (par == 2) ? ^d : ~^d;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int u, input logic [7:0] d);
        @(negedge clk);
        chk("ready_before_accept", 32'(ready[u]), 32'd1);
        data[u]  = d;
        valid[u] = 1'b1;
        @(negedge clk);
        chk("accept_ready_busy", {30'd0, ready[u], busy[u]}, 32'b01);
        valid[u] = 1'b0;
        data[u]  = 8'($urandom);
    endtask

    // Follows one frame from its start edge; optionally holds valid for a
    // back-to-back word nd so it is taken on the first edge with ready=1.
    task automatic frame(input int u, input logic [7:0] d, input int par, input int stops,
                         input bit junk, input bit b2b, input logic [7:0] nd);
        int nb;
        int w;
        int bad;
        nb = 10 + ((par != 0) ? 1 : 0) + (stops - 1);
        w  = 0;
        while (tx[u] === 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("start_edge", 32'(tx[u]), 32'd0);
        chk("align_wait_le4", 32'(w >= 1 && w <= 4), 32'd1);
        bad = 0;
        for (int i = 0; i <= 64 * nb; i++) begin
            if (i < 64 * nb) begin
                if (tx[u] !== exp_bit(d, par, i / 64)) bad++;
                if (i % 64 == 63) begin
                    chk($sformatf("tx_bit%0d_bad_samples", i / 64), 32'(bad), 32'd0);
                    bad = 0;
                end
            end
            if (i == 64 * nb - 1) chk("ready_low_before_end", 32'(ready[u]), 32'd0);
            if (i == 64 * nb) begin
                chk("ready_at_end", 32'(ready[u]), 32'd1);
                chk("busy_at_end", 32'(busy[u]), 32'd0);
                chk("tx_idle_at_end", 32'(tx[u]), 32'd1);
            end
            if (i < 64 * nb) begin
                if (junk && i < 64 * nb - 2) begin
                    valid[u] = 1'($urandom);
                    data[u]  = 8'($urandom);
                end else if (i == 64 * nb - 2) begin
                    valid[u] = b2b;
                    data[u]  = nd;
                end
                @(negedge clk);
            end
        end
        if (b2b) begin
            @(negedge clk);
            chk("b2b_accept_next_clk", {30'd0, ready[u], busy[u]}, 32'b01);
            valid[u] = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] r;
        int         bad;
        int         w;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        valid  = '0;
        for (int u = 0; u < 3; u++) data[u] = 8'hFF;

        #23;
        chk("reset_outputs", {23'd0, tx, ready, busy}, {23'd0, 3'b111, 3'b111, 3'b000});
        @(negedge clk);
        rst_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 3'b111 || ready !== 3'b111 || busy !== 3'b000) bad++;
        end
        chk("idle_steady_bad_cycles", 32'(bad), 32'd0);

        accept(0, 8'h55);
        frame(0, 8'h55, 0, 1, 1'b0, 1'b0, 8'h00);

        accept(1, 8'h07);
        frame(1, 8'h07, 2, 2, 1'b0, 1'b0, 8'h00);
        accept(2, 8'h07);
        frame(2, 8'h07, 1, 1, 1'b0, 1'b0, 8'h00);

        accept(0, 8'hA3);
        frame(0, 8'hA3, 0, 1, 1'b0, 1'b1, 8'h3C);
        frame(0, 8'h3C, 0, 1, 1'b0, 1'b0, 8'h00);

        r = 8'($urandom);
        accept(0, r);
        frame(0, r, 0, 1, 1'b1, 1'b0, 8'h00);

        for (int n = 0; n < 3; n++) begin
            r = 8'($urandom);
            accept(0, r);
            frame(0, r, 0, 1, 1'b0, 1'b0, 8'h00);
        end
        for (int n = 0; n < 2; n++) begin
            r = 8'($urandom);
            accept(1, r);
            frame(1, r, 2, 2, 1'b1, 1'b0, 8'h00);
            r = 8'($urandom);
            accept(2, r);
            frame(2, r, 1, 1, 1'b0, 1'b0, 8'h00);
        end

        // Abort in the middle of data bit 4 (frame bit 5), which is forced low.
        r = 8'($urandom) & 8'hEF;
        accept(0, r);
        w = 0;
        while (tx[0] === 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        repeat (64 * 5 + 20) @(negedge clk);
        chk("mid_data_bit4_low", {30'd0, tx[0], busy[0]}, 32'b01);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {29'd0, tx[0], ready[0], busy[0]}, 32'b110);
        @(negedge clk);
        rst_n = 1'b1;
        r = 8'($urandom);
        accept(0, r);
        frame(0, r, 0, 1, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
